lsnn_step_scheduler: RTL and testbench



---
 rtl/lsnn_pkg.sv | 14 +
 rtl/lsnn_refrac_bank.sv | 36 +++
 rtl/lsnn_step_scheduler.sv | 146 ++++++++++++++
 tb/tb_lsnn_step_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsnn_pkg.sv
// Shared types and widths for the LSNN step scheduler.
package lsnn_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      PUBLISH
   } sched_state_t;

   localparam int STEP_CNT_W = 8;
   localparam int REFRAC_W   = 3;

endpackage

// File: rtl/lsnn_refrac_bank.sv
// Per-neuron refractory down-counters; a neuron is refractory while its count is nonzero.
module lsnn_refrac_bank
   import lsnn_pkg::*;
#(
   parameter int NUM_NEURONS  = 8,
   parameter int REFRAC_STEPS = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load_i,
   input  logic [NUM_NEURONS-1:0] fired_i,
   output logic [NUM_NEURONS-1:0] refr_o
);

   logic [REFRAC_W-1:0] cnt_q [NUM_NEURONS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < NUM_NEURONS; n++) cnt_q[n] <= '0;
      end else if (load_i) begin
         for (int n = 0; n < NUM_NEURONS; n++) begin
            if (fired_i[n]) begin
               cnt_q[n] <= REFRAC_W'(REFRAC_STEPS);
            end else if (cnt_q[n] != '0) begin
               cnt_q[n] <= cnt_q[n] - REFRAC_W'(1);
            end
         end
      end
   end

   always_comb begin
      refr_o = '0;
      for (int n = 0; n < NUM_NEURONS; n++) refr_o[n] = |cnt_q[n];
   end

endmodule

// File: rtl/lsnn_step_scheduler.sv
// Time-multiplexes one LSNN neuron datapath over NUM_NEURONS neurons per timestep.
// Optional refractory skipping is enabled with LSNN_REFRACTORY_EN.
//
// state   | meaning
// IDLE    | waiting for step_start
// ISSUE   | request for neuron idx held on dp_valid (or skipped if refractory)
// WAIT    | request accepted, waiting for dp_done
// PUBLISH | copy accumulator to out_spikes, pulse step_done
module lsnn_step_scheduler
   import lsnn_pkg::*;
#(
   parameter int NUM_NEURONS  = 8,
   parameter int IDX_W        = 3,
   parameter int REFRAC_STEPS = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   step_start,
   input  logic [NUM_NEURONS-1:0] in_spikes,
   output logic                   busy,
   output logic                   step_dropped,
   output logic                   dp_valid,
   output logic [IDX_W-1:0]       dp_idx,
   output logic                   dp_in_spike,
   input  logic                   dp_ready,
   input  logic                   dp_done,
   input  logic                   dp_spike,
   output logic [NUM_NEURONS-1:0] out_spikes,
   output logic                   step_done,
   output logic [STEP_CNT_W-1:0]  step_count
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

   sched_state_t           state_q;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [NUM_NEURONS-1:0] spikes_q, accum_q, out_spikes_q;
   logic [NUM_NEURONS-1:0] refr_w;
   logic                   busy_q, step_dropped_q, dp_valid_q, dp_in_spike_q, step_done_q;
   logic [IDX_W-1:0]       dp_idx_q;
   logic [STEP_CNT_W-1:0]  step_count_q;
   logic                   advance_w, result_w;

   // A neuron finishes either by datapath completion or by being skipped as refractory.
   always_comb begin
      idx_d     = idx_q + IDX_W'(1);
      advance_w = 1'b0;
      result_w  = 1'b0;
      case (state_q)
         ISSUE: advance_w = refr_w[idx_q];
         WAIT: begin
            advance_w = dp_done;
            result_w  = dp_spike;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         idx_q          <= '0;
         spikes_q       <= '0;
         accum_q        <= '0;
         out_spikes_q   <= '0;
         busy_q         <= 1'b0;
         step_dropped_q <= 1'b0;
         dp_valid_q     <= 1'b0;
         dp_idx_q       <= '0;
         dp_in_spike_q  <= 1'b0;
         step_done_q    <= 1'b0;
         step_count_q   <= '0;
      end else begin
         step_done_q    <= 1'b0;
         step_dropped_q <= step_start && (state_q != IDLE);
         if (advance_w) begin
            accum_q[idx_q] <= result_w;
            if (idx_q == LAST_IDX) begin
               state_q    <= PUBLISH;
               dp_valid_q <= 1'b0;
            end else begin
               state_q       <= ISSUE;
               idx_q         <= idx_d;
               dp_idx_q      <= idx_d;
               dp_in_spike_q <= spikes_q[idx_d];
               dp_valid_q    <= !refr_w[idx_d];
            end
         end else begin
            case (state_q)
               IDLE: begin
                  busy_q <= step_start;
                  if (step_start) begin
                     state_q       <= ISSUE;
                     spikes_q      <= in_spikes;
                     accum_q       <= '0;
                     idx_q         <= '0;
                     dp_idx_q      <= '0;
                     dp_in_spike_q <= in_spikes[0];
                     dp_valid_q    <= !refr_w[0];
                  end
               end
               ISSUE: begin
                  if (dp_valid_q && dp_ready) begin
                     dp_valid_q <= 1'b0;
                     state_q    <= WAIT;
                  end
               end
               PUBLISH: begin
                  out_spikes_q <= accum_q;
                  step_done_q  <= 1'b1;
                  step_count_q <= step_count_q + STEP_CNT_W'(1);
                  state_q      <= IDLE;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef LSNN_REFRACTORY_EN
   lsnn_refrac_bank #(
      .NUM_NEURONS  (NUM_NEURONS),
      .REFRAC_STEPS (REFRAC_STEPS)
   ) u_refrac (
      .clk     (clk),
      .rst     (rst),
      .load_i  (state_q == PUBLISH),
      .fired_i (accum_q),
      .refr_o  (refr_w)
   );
`else
   assign refr_w = '0;
   logic unused_refrac_cfg;
   assign unused_refrac_cfg = ^REFRAC_STEPS;
`endif

   assign busy         = busy_q;
   assign step_dropped = step_dropped_q;
   assign dp_valid     = dp_valid_q;
   assign dp_idx       = dp_idx_q;
   assign dp_in_spike  = dp_in_spike_q;
   assign out_spikes   = out_spikes_q;
   assign step_done    = step_done_q;
   assign step_count   = step_count_q;

endmodule

// File: tb/tb_lsnn_step_scheduler.sv
// Self-checking bench for lsnn_step_scheduler; refractory scenario runs when LSNN_REFRACTORY_EN is defined.
module tb_lsnn_step_scheduler;

   localparam int N  = 8;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst, step_start;
   logic [N-1:0]  in_spikes;
   logic          busy, step_dropped, dp_valid;
   logic [IW-1:0] dp_idx;
   logic          dp_in_spike, dp_ready, dp_done, dp_spike;
   logic [N-1:0]  out_spikes;
   logic          step_done;
   logic [7:0]    step_count;

   lsnn_step_scheduler #(.NUM_NEURONS(N), .IDX_W(IW), .REFRAC_STEPS(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .step_start   (step_start),
      .in_spikes    (in_spikes),
      .busy         (busy),
      .step_dropped (step_dropped),
      .dp_valid     (dp_valid),
      .dp_idx       (dp_idx),
      .dp_in_spike  (dp_in_spike),
      .dp_ready     (dp_ready),
      .dp_done      (dp_done),
      .dp_spike     (dp_spike),
      .out_spikes   (out_spikes),
      .step_done    (step_done),
      .step_count   (step_count)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   typedef struct {
      logic [7:0] out;
      logic [7:0] cnt;
      int         lat;
      int         start;
   } exp_t;
   exp_t sb[$];
   exp_t e;
   logic [7:0] exp_count = '0;

   // Datapath model: result = in_spike ^ flip_mask[idx], done one cycle after accept.
   logic [N-1:0] flip_mask = '0;
   logic [N-1:0] cur_in    = '0;
   int           stall_idx  = -1;
   int           stall_left = 0;
   int           acc_cnt[N];
   int           valid_cyc[N];
   int           inspk_bad = 0;
   logic         pend = 1'b0, pend_spk = 1'b0;

   initial begin
      dp_ready = 1'b0;
      dp_done  = 1'b0;
      dp_spike = 1'b0;
      forever begin
         @(negedge clk);
         dp_done  = pend;
         dp_spike = pend_spk;
         if (dp_valid) begin
            valid_cyc[dp_idx]++;
            if (dp_in_spike !== cur_in[dp_idx]) inspk_bad++;
         end
         if (dp_valid && int'(dp_idx) == stall_idx && stall_left > 0) begin
            dp_ready = 1'b0;
            stall_left--;
         end else begin
            dp_ready = 1'b1;
         end
         pend     = dp_valid && dp_ready && !rst;
         pend_spk = dp_in_spike ^ flip_mask[dp_idx];
         if (pend) acc_cnt[dp_idx]++;
      end
   end

   // Scoreboard monitor
   int   done_cnt  = 0;
   int   drop_cnt  = 0;
   logic prev_done = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         if (step_dropped) drop_cnt++;
         if (step_done) begin
            done_cnt++;
            check("step_done_width", 32'(prev_done), 0);
            if (sb.size() == 0) begin
               check("sb_nonempty", 32'(sb.size()), 1);
            end else begin
               e = sb.pop_front();
               check("out_spikes", 32'(out_spikes), 32'(e.out));
               check("step_count", 32'(step_count), 32'(e.cnt));
               if (e.lat >= 0) check("latency", 32'(cyc - e.start), 32'(e.lat));
            end
         end
         prev_done = step_done;
      end
   end

   task automatic start_step(input logic [7:0] in, input int lat, input logic [7:0] exp_out);
      cur_in    = in;
      in_spikes = in;
      inspk_bad = 0;
      foreach (acc_cnt[i]) begin
         acc_cnt[i]   = 0;
         valid_cyc[i] = 0;
      end
      exp_count = exp_count + 8'd1;
      sb.push_back('{exp_out, exp_count, lat, cyc});
      step_start = 1'b1;
      @(negedge clk);
      #1 step_start = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int k = 0;
      while (done_cnt < target && k < 300) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (done_cnt < target) begin
         check("step_done_timeout", 32'(done_cnt), 32'(target));
         sb.delete();
      end
   endtask

   task automatic run_step(input logic [7:0] in, input int lat, input logic [7:0] exp_out);
      int t = done_cnt + 1;
      start_step(in, lat, exp_out);
      wait_done(t);
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      step_start = 1'b0;
      in_spikes  = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy",         32'(busy), 0);
      check("rst_dp_valid",     32'(dp_valid), 0);
      check("rst_step_done",    32'(step_done), 0);
      check("rst_step_dropped", 32'(step_dropped), 0);
      check("rst_out_spikes",   32'(out_spikes), 0);
      check("rst_step_count",   32'(step_count), 0);
      check("rst_dp_idx",       32'(dp_idx), 0);
      check("rst_dp_in_spike",  32'(dp_in_spike), 0);
      rst = 1'b0;
      sb.delete();
      exp_count = '0;
      @(negedge clk);
      #1;
   endtask

   typedef struct {
      logic [7:0] in;
      logic [7:0] flip;
      int         si;
      int         sn;
      logic [7:0] exp_out;
      int         lat;
   } vec_t;
   vec_t vecs[5];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      logic [7:0] ones;
      logic [7:0] r;
      int         t, d0, found;

      do_reset();

`ifdef LSNN_REFRACTORY_EN
      run_step(8'h01, 18, 8'h01);
      run_step(8'h01, 17, 8'h00);
      check("refrac_skip_step2", 32'(acc_cnt[0]), 0);
      run_step(8'h01, 17, 8'h00);
      check("refrac_skip_step3", 32'(acc_cnt[0]), 0);
      run_step(8'h01, 18, 8'h01);
      check("refrac_issue_step4", 32'(acc_cnt[0]), 1);
`else
      vecs[0] = '{8'hA5, 8'h00, -1, 0, 8'hA5, 18};
      vecs[1] = '{8'h3C, 8'h00,  3, 5, 8'h3C, 23};
      vecs[2] = '{8'hFF, 8'h0F, -1, 0, 8'hF0, 18};
      vecs[3] = '{8'h00, 8'hC3,  7, 2, 8'hC3, 20};
      vecs[4] = '{8'h81, 8'h00,  0, 1, 8'h81, 19};

      foreach (vecs[v]) begin
         flip_mask  = vecs[v].flip;
         stall_idx  = vecs[v].si;
         stall_left = vecs[v].sn;
         run_step(vecs[v].in, vecs[v].lat, vecs[v].exp_out);
         @(negedge clk);
         #1;
         check("busy_after_done", 32'(busy), 0);
         for (int i = 0; i < N; i++) ones[i] = (acc_cnt[i] == 1);
         check("one_accept_each", 32'(ones), 32'hFF);
         check("dp_in_spike_stable", 32'(inspk_bad), 0);
         if (vecs[v].si >= 0)
            check("stall_valid_cycles", 32'(valid_cyc[vecs[v].si]), 32'(vecs[v].sn + 1));
      end
      flip_mask = '0;
      stall_idx = -1;

      // step_start four cycles into a running step is dropped
      d0 = drop_cnt;
      t  = done_cnt + 1;
      start_step(8'h96, 18, 8'h96);
      repeat (3) begin
         @(negedge clk);
         #1;
      end
      in_spikes  = 8'hFF;
      step_start = 1'b1;
      @(negedge clk);
      #1 step_start = 1'b0;
      check("dropped_pulse", 32'(step_dropped), 1);
      @(negedge clk);
      #1;
      check("dropped_single", 32'(step_dropped), 0);
      wait_done(t);
      check("drop_count", 32'(drop_cnt - d0), 1);

      // step_start in the PUBLISH cycle is dropped too
      t = done_cnt + 1;
      start_step(8'h5A, 18, 8'h5A);
      repeat (16) begin
         @(negedge clk);
         #1;
      end
      step_start = 1'b1;
      @(negedge clk);
      #1 step_start = 1'b0;
      check("publish_drop", 32'(step_dropped), 1);
      wait_done(t);
      @(negedge clk);
      #1;
      check("publish_drop_no_start", 32'(busy), 0);

      // reset while waiting on neuron 5
      start_step(8'h77, 18, 8'h77);
      found = 0;
      for (int k = 0; k < 40 && found == 0; k++) begin
         if (!dp_valid && busy && dp_idx == 3'd5) found = 1;
         else begin
            @(negedge clk);
            #1;
         end
      end
      check("reach_wait_idx5", 32'(found), 1);
      rst = 1'b1;
      @(negedge clk);
      #1 rst = 1'b0;
      check("midrst_busy",       32'(busy), 0);
      check("midrst_dp_valid",   32'(dp_valid), 0);
      check("midrst_out_spikes", 32'(out_spikes), 0);
      check("midrst_step_count", 32'(step_count), 0);
      sb.delete();
      exp_count = '0;
      @(negedge clk);
      #1;
      run_step(8'h24, 18, 8'h24);

      // back-to-back steps through the step_count wrap
      d0 = drop_cnt;
      for (int i = 0; i < 255; i++) begin
         r = 8'($urandom_range(0, 255));
         run_step(r, 18, r);
      end
      check("wrap_to_zero", 32'(step_count), 0);
      r = 8'($urandom_range(0, 255));
      run_step(r, 18, r);
      check("after_wrap_one", 32'(step_count), 1);
      check("b2b_no_drops", 32'(drop_cnt - d0), 0);
`endif

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
